aes_bus_master: RTL and testbench

//  Initiator for the AES core's 8-bit-address / 32-bit-data register interface.

---
 rtl/aes_bus_master.sv | 264 ++++++++++++++++++++++++++
 tb/tb_aes_bus_master.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_bus_master.sv
// rtl/aes_bus_master.sv - bus initiator sequencing one AES request over the 8-bit/32-bit register interface
module aes_bus_master #(
    parameter int SETTLE_CYCLES = 3,
    parameter int POLL_TIMEOUT  = 1024
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         encdec,
    input  logic         keylen,
    input  logic         key_init,
    input  logic [255:0] key,
    input  logic [127:0] block,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [127:0] result,
    output logic         cs,
    output logic         we,
    output logic [7:0]   address,
    output logic [31:0]  write_data,
    input  logic [31:0]  read_data
);

    // One counter serves both the settle delay and the poll budget.
    // SETTLE_CYCLES is expected to be at least 1.
    localparam int CNT_W = $clog2(POLL_TIMEOUT + SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] POLL_LAST   = CNT_W'(POLL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [7:0] A_CTRL   = 8'h08;
    localparam logic [7:0] A_STATUS = 8'h09;
    localparam logic [7:0] A_CFG    = 8'h0A;
    localparam logic [7:0] A_KEY    = 8'h10;
    localparam logic [7:0] A_BLK    = 8'h20;
    localparam logic [7:0] A_RES    = 8'h30;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_CFG, S_WR_KEY, S_WR_INIT, S_SETTLE_RDY, S_POLL_RDY,
        S_WR_BLK, S_WR_NEXT, S_SETTLE_VLD, S_POLL_VLD, S_RD_RES, S_DONE
    } state_t;

    // Bus outputs are registered as one bundle; all-zero means an idle bus cycle.
    typedef struct packed {
        logic        cs;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
    } bus_t;

    function automatic bus_t bus_wr(input logic [7:0] a, input logic [31:0] d);
        bus_t b;
        b.cs   = 1'b1;
        b.we   = 1'b1;
        b.addr = a;
        b.data = d;
        return b;
    endfunction

    function automatic bus_t bus_rd(input logic [7:0] a);
        bus_t b;
        b.cs   = 1'b1;
        b.we   = 1'b0;
        b.addr = a;
        b.data = 32'h0;
        return b;
    endfunction

    // Word i of the key is the i-th 32-bit word counted from the MSB end.
    function automatic logic [31:0] key_word(input logic [255:0] k, input logic [2:0] i);
        logic [255:0] s;
        s = k << {i, 5'b0};
        return s[255:224];
    endfunction

    function automatic logic [31:0] blk_word(input logic [127:0] b, input logic [1:0] i);
        logic [127:0] s;
        s = b << {i, 5'b0};
        return s[127:96];
    endfunction

    state_t           state_q, state_d;
    bus_t             bus_q, bus_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [127:0]     result_q, result_d;
    logic             encdec_q, encdec_d;
    logic             keylen_q, keylen_d;
    logic             key_init_q, key_init_d;
    logic [255:0]     key_q, key_d;
    logic [127:0]     block_q, block_d;

    logic [2:0]       idx_next;
    logic [2:0]       key_last;
    logic [6:0]       res_sh;

    assign idx_next = idx_q + 3'd1;
    assign key_last = keylen_q ? 3'd7 : 3'd3;
    assign res_sh   = {~idx_q[1:0], 5'b0};

    // Next-state and next-output computation: each branch also emits the bus cycle of the state it enters.
    always_comb begin
        state_d    = state_q;
        bus_d      = '0;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        result_d   = result_q;
        encdec_d   = encdec_q;
        keylen_d   = keylen_q;
        key_init_d = key_init_q;
        key_d      = key_q;
        block_d    = block_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    encdec_d   = encdec;
                    keylen_d   = keylen;
                    key_init_d = key_init;
                    key_d      = key;
                    block_d    = block;
                    busy_d     = 1'b1;
                    error_d    = 1'b0;
                    state_d    = S_WR_CFG;
                    bus_d      = bus_wr(A_CFG, {30'b0, keylen, encdec});
                end
            end
            S_WR_CFG: begin
                cnt_d = '0;
                idx_d = 3'd0;
                if (key_init_q) begin
                    state_d = S_WR_KEY;
                    bus_d   = bus_wr(A_KEY, key_word(key_q, 3'd0));
                end else begin
                    // No key expansion: the first status read still guards against a busy core.
                    state_d = S_POLL_RDY;
                    bus_d   = bus_rd(A_STATUS);
                end
            end
            S_WR_KEY: begin
                if (idx_q == key_last) begin
                    state_d = S_WR_INIT;
                    bus_d   = bus_wr(A_CTRL, 32'h1);
                end else begin
                    idx_d = idx_next;
                    bus_d = bus_wr(A_KEY + {5'b0, idx_next}, key_word(key_q, idx_next));
                end
            end
            S_WR_INIT: begin
                state_d = S_SETTLE_RDY;
                cnt_d   = '0;
            end
            S_SETTLE_RDY, S_SETTLE_VLD: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = (state_q == S_SETTLE_RDY) ? S_POLL_RDY : S_POLL_VLD;
                    cnt_d   = '0;
                    bus_d   = bus_rd(A_STATUS);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_POLL_RDY, S_POLL_VLD: begin
                if ((state_q == S_POLL_RDY) ? read_data[0] : (read_data[1] & read_data[0])) begin
                    idx_d = 3'd0;
                    if (state_q == S_POLL_RDY) begin
                        state_d = S_WR_BLK;
                        bus_d   = bus_wr(A_BLK, blk_word(block_q, 2'd0));
                    end else begin
                        state_d = S_RD_RES;
                        bus_d   = bus_rd(A_RES);
                    end
                end else if (cnt_q == POLL_LAST) begin
                    // Poll budget exhausted: abort with error, result untouched.
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    bus_d = bus_rd(A_STATUS);
                end
            end
            S_WR_BLK: begin
                if (idx_q == 3'd3) begin
                    state_d = S_WR_NEXT;
                    bus_d   = bus_wr(A_CTRL, 32'h2);
                end else begin
                    idx_d = idx_next;
                    bus_d = bus_wr(A_BLK + {5'b0, idx_next}, blk_word(block_q, idx_next[1:0]));
                end
            end
            S_WR_NEXT: begin
                state_d = S_SETTLE_VLD;
                cnt_d   = '0;
            end
            S_RD_RES: begin
                result_d = (result_q & ~(128'hffff_ffff << res_sh)) | ({96'b0, read_data} << res_sh);
                if (idx_q == 3'd3) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_next;
                    bus_d = bus_rd(A_RES + {5'b0, idx_next});
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any request without a done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            bus_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            result_q   <= '0;
            encdec_q   <= 1'b0;
            keylen_q   <= 1'b0;
            key_init_q <= 1'b0;
            key_q      <= '0;
            block_q    <= '0;
        end else begin
            state_q    <= state_d;
            bus_q      <= bus_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            result_q   <= result_d;
            encdec_q   <= encdec_d;
            keylen_q   <= keylen_d;
            key_init_q <= key_init_d;
            key_q      <= key_d;
            block_q    <= block_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign result     = result_q;
    assign cs         = bus_q.cs;
    assign we         = bus_q.we;
    assign address    = bus_q.addr;
    assign write_data = bus_q.data;

endmodule

// File: tb/tb_aes_bus_master.sv
// tb/tb_aes_bus_master.sv - self-checking bench for aes_bus_master with a register-level slave model
module tb_aes_bus_master;

    localparam int SETTLE = 3;
    localparam int PTO    = 16;

    localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PLAIN = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         encdec = 1'b0;
    logic         keylen = 1'b0;
    logic         key_init = 1'b0;
    logic [255:0] key = '0;
    logic [127:0] block = '0;
    logic         busy, done, error, cs, we;
    logic [127:0] result;
    logic [7:0]   address;
    logic [31:0]  write_data, read_data;

    always #5 clk = ~clk;

    aes_bus_master #(.SETTLE_CYCLES(SETTLE), .POLL_TIMEOUT(PTO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .encdec(encdec), .keylen(keylen),
        .key_init(key_init), .key(key), .block(block), .busy(busy), .done(done),
        .error(error), .result(result), .cs(cs), .we(we), .address(address),
        .write_data(write_data), .read_data(read_data)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stand-in cipher: known-answer vectors, otherwise a keyed mix that depends on every input.
    function automatic logic [127:0] cipher(input logic [255:0] k, input logic kl,
                                            input logic [127:0] b, input logic enc);
        if (!kl && k[255:128] == K128 && enc && b == PLAIN) return CT128;
        if (!kl && k[255:128] == K128 && !enc && b == CT128) return PLAIN;
        if (kl && k == K256 && enc && b == PLAIN) return CT256;
        return b ^ k[255:128] ^ (kl ? k[127:0] : 128'h0) ^
               (enc ? {4{32'h13579bdf}} : {4{32'h2468ace0}});
    endfunction

    // Slave: register file, key snapshot at INIT, result computed at NEXT, status with latency.
    logic [31:0]  s_key [8];
    logic [31:0]  s_blk [4];
    logic [31:0]  s_cfg = '0;
    logic [255:0] s_xkey = '0;
    logic         s_xlen = 1'b0;
    logic [127:0] s_res = '0;
    logic         s_ready = 1'b1, s_valid = 1'b0, s_pend = 1'b0;
    int           s_busy = 0;
    bit           s_stuck = 1'b0;
    int           s_fixed_lat = 0;
    logic [127:0] rd_tmp;

    always @(posedge clk) begin
        if (s_busy > 0) begin
            s_busy <= s_busy - 1;
            if (s_busy == 1) begin
                s_ready <= 1'b1;
                if (s_pend) begin
                    s_valid <= 1'b1;
                    s_pend  <= 1'b0;
                end
            end
        end
        if (cs && we) begin
            if (address == 8'h0a) s_cfg <= write_data;
            else if (address[7:3] == 5'h02) s_key[address[2:0]] <= write_data;
            else if (address[7:2] == 6'h08) s_blk[address[1:0]] <= write_data;
            else if (address == 8'h08) begin
                s_ready <= 1'b0;
                s_busy  <= (s_fixed_lat != 0) ? s_fixed_lat : int'($urandom_range(1, 10));
                if (write_data[0]) begin
                    s_xkey <= {s_key[0], s_key[1], s_key[2], s_key[3], s_key[4], s_key[5], s_key[6], s_key[7]};
                    s_xlen <= s_cfg[1];
                end
                if (write_data[1]) begin
                    s_res   <= cipher(s_xkey, s_xlen, {s_blk[0], s_blk[1], s_blk[2], s_blk[3]}, s_cfg[0]);
                    s_pend  <= 1'b1;
                    s_valid <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        read_data = 32'h0;
        rd_tmp    = s_res << {address[1:0], 5'b0};
        if (cs && !we) begin
            if (address == 8'h09) read_data = s_stuck ? 32'h0 : {30'b0, s_valid, s_ready};
            else if (address[7:2] == 6'h0c) read_data = rd_tmp[127:96];
        end
    end

    // Bus monitor: full trace, trace without status reads, idle-bus cleanliness, settle gaps, done pulses.
    typedef logic [40:0] acc_t;
    acc_t trace_all[$];
    acc_t trace_ns[$];
    acc_t exp_q[$];
    int   n_stat, n_done, n_idle_bad, n_settle_bad, gap;
    bit   gap_arm;

    always @(negedge clk) begin
        acc_t a;
        if (reset_n) begin
            if (cs) begin
                a = {we, address, we ? write_data : 32'h0};
                trace_all.push_back(a);
                if (!we && address == 8'h09) n_stat++;
                else trace_ns.push_back(a);
            end else if (we || address != 8'h0 || write_data != 32'h0) begin
                n_idle_bad++;
            end
            if (done) n_done++;
            if (cs && we && address == 8'h08) begin
                gap_arm = 1'b1;
                gap     = 0;
            end else if (gap_arm) begin
                if (!cs) gap++;
                else begin
                    if (we || address != 8'h09 || gap != SETTLE) n_settle_bad++;
                    gap_arm = 1'b0;
                end
            end
        end
    end

    // Expected non-status access list, derived from the request alone.
    task automatic build_exp(input logic e, input logic kl, input logic ki, input logic [255:0] k,
                             input logic [127:0] b, input bit to);
        exp_q.delete();
        exp_q.push_back({1'b1, 8'h0a, 30'b0, kl, e});
        if (ki) begin
            for (int i = 0; i < (kl ? 8 : 4); i++)
                exp_q.push_back({1'b1, 8'(8'h10 + i), k[255 - 32*i -: 32]});
            exp_q.push_back({1'b1, 8'h08, 32'h1});
        end
        if (!to) begin
            for (int i = 0; i < 4; i++)
                exp_q.push_back({1'b1, 8'(8'h20 + i), b[127 - 32*i -: 32]});
            exp_q.push_back({1'b1, 8'h08, 32'h2});
            for (int i = 0; i < 4; i++)
                exp_q.push_back({1'b0, 8'(8'h30 + i), 32'h0});
        end
    endtask

    logic [127:0] got_res;
    logic         got_err;
    bit           got_done;

    task automatic run_req(input logic e, input logic kl, input logic ki, input logic [255:0] k,
                           input logic [127:0] b);
        @(negedge clk);
        trace_all.delete();
        trace_ns.delete();
        n_stat = 0; n_done = 0; n_idle_bad = 0; n_settle_bad = 0; gap_arm = 1'b0;
        encdec = e; keylen = kl; key_init = ki; key = k; block = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 600 && !done; i++) @(negedge clk);
        got_done = done;
        got_res  = result;
        got_err  = error;
        @(negedge clk);
    endtask

    task automatic check_req(input string tag, input logic e, input logic kl, input logic ki,
                             input logic [255:0] k, input logic [127:0] b, input bit to,
                             input logic [127:0] exp_res, input logic exp_err);
        int first_bad;
        chk({tag, " done_seen"}, got_done, 1'b1);
        chk({tag, " result"}, got_res, exp_res);
        chk({tag, " error"}, got_err, exp_err);
        chk({tag, " busy_after"}, busy, 1'b0);
        chk({tag, " done_pulses"}, n_done, 1);
        chk({tag, " idle_bus"}, n_idle_bad, 0);
        chk({tag, " settle_gap"}, n_settle_bad, 0);
        build_exp(e, kl, ki, k, b, to);
        chk({tag, " trace_len"}, trace_ns.size(), exp_q.size());
        first_bad = -1;
        for (int i = 0; i < exp_q.size() && i < trace_ns.size(); i++)
            if (first_bad < 0 && trace_ns[i] !== exp_q[i]) first_bad = i;
        chk({tag, " trace_first_diff"}, first_bad, -1);
        if (to) chk({tag, " status_reads"}, n_stat, PTO);
    endtask

    typedef struct {
        string        name;
        logic         e, kl, ki;
        logic [255:0] k;
        logic [127:0] b;
        bit           stuck;
        logic [127:0] exp_res;
        logic         exp_err;
    } vec_t;

    vec_t         vt[4];
    logic [255:0] m_key;
    logic         m_kl;
    logic [127:0] m_res;
    logic [255:0] rk;
    logic [127:0] rb, prev_res;
    logic         re, rkl, rki;
    acc_t         ref_trace[$];
    bit           seen;

    initial begin
        vt[0] = '{"aes256", 1'b1, 1'b1, 1'b1, K256, PLAIN, 1'b0, CT256, 1'b0};
        vt[1] = '{"aes128", 1'b1, 1'b0, 1'b1, {K128, 128'h0}, PLAIN, 1'b0, CT128, 1'b0};
        vt[2] = '{"dec_reuse", 1'b0, 1'b0, 1'b0, 256'h0, CT128, 1'b0, PLAIN, 1'b0};
        vt[3] = '{"timeout", 1'b1, 1'b0, 1'b1, {128'hdeadbeef_cafef00d_01234567_89abcdef, 128'h0},
                  PLAIN, 1'b1, PLAIN, 1'b1};

        #12;
        chk("reset cs", cs, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset error", error, 1'b0);
        chk("reset result", result, 128'h0);
        chk("reset addr_wdata", {address, write_data}, 40'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Known-answer and timeout vectors.
        for (int i = 0; i < 4; i++) begin
            s_stuck = vt[i].stuck;
            run_req(vt[i].e, vt[i].kl, vt[i].ki, vt[i].k, vt[i].b);
            s_stuck = 1'b0;
            check_req(vt[i].name, vt[i].e, vt[i].kl, vt[i].ki, vt[i].k, vt[i].b,
                      vt[i].stuck, vt[i].exp_res, vt[i].exp_err);
            if (vt[i].ki) begin
                m_key = vt[i].k;
                m_kl  = vt[i].kl;
            end
            m_res = vt[i].exp_res;
        end
        repeat (12) @(negedge clk);

        // Randomized requests against the model: key reuse follows the last INIT.
        for (int n = 0; n < 20; n++) begin
            re  = 1'($urandom);
            rkl = 1'($urandom);
            rki = 1'($urandom);
            rk  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rb  = {$urandom, $urandom, $urandom, $urandom};
            if (rki) begin
                m_key = rk;
                m_kl  = rkl;
            end
            m_res = cipher(m_key, m_kl, rb, re);
            run_req(re, rkl, rki, rk, rb);
            check_req($sformatf("rand%0d", n), re, rkl, rki, rk, rb, 1'b0, m_res, 1'b0);
        end
        repeat (12) @(negedge clk);

        // Start pulse during POLL_RDY must not perturb the bus trace.
        s_fixed_lat = 5;
        run_req(1'b1, 1'b0, 1'b1, {K128, 128'h0}, PLAIN);
        check_req("ref_run", 1'b1, 1'b0, 1'b1, {K128, 128'h0}, PLAIN, 1'b0, CT128, 1'b0);
        ref_trace = trace_all;
        repeat (12) @(negedge clk);
        seen = 1'b0;
        fork
            run_req(1'b1, 1'b0, 1'b1, {K128, 128'h0}, PLAIN);
            begin
                for (int i = 0; i < 100 && !seen; i++) begin
                    @(negedge clk);
                    if (cs && !we && address == 8'h09) seen = 1'b1;
                end
                start = 1'b1;
                key   = '1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        chk("inject poll_seen", seen, 1'b1);
        check_req("inject", 1'b1, 1'b0, 1'b1, {K128, 128'h0}, PLAIN, 1'b0, CT128, 1'b0);
        chk("inject trace_len", trace_all.size(), ref_trace.size());
        chk("inject trace_same", trace_all == ref_trace, 1'b1);
        s_fixed_lat = 0;
        repeat (12) @(negedge clk);

        // Reset while block words are being written.
        prev_res = result;
        chk("pre_reset result_nonzero", prev_res != 128'h0, 1'b1);
        @(negedge clk);
        encdec = 1'b1; keylen = 1'b0; key_init = 1'b1; key = {K128, 128'h0}; block = PLAIN;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (cs && we && address[7:2] == 6'h08) seen = 1'b1;
            else @(negedge clk);
        end
        chk("wr_blk seen", seen, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("abort cs", cs, 1'b0);
        chk("abort busy", busy, 1'b0);
        chk("abort result", result, 128'h0);
        chk("abort done", done, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        run_req(1'b1, 1'b1, 1'b1, K256, PLAIN);
        check_req("after_reset", 1'b1, 1'b1, 1'b1, K256, PLAIN, 1'b0, CT256, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
